// File: rtl/weight_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : weight_mem_arbiter
// Purpose  : Sequencer/arbiter for the shared single-port weight memory
//            (synchronous read, 1-cycle latency). Serves the host load port,
//            the inference read port and the learning write-back port.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk, rst            : clock, synchronous active-high reset
//   i_phase_infer       : 0 = host load phase, 1 = inference/learning phase
//   i_host_*            : host write request (req/addr/wdata), o_host_ack
//   i_rd_*              : inference read request (req/addr),
//                         o_rd_valid / o_rd_data
//   i_wb_*              : write-back request (req/addr/wdata), o_wb_ack
//   o_mem_we/addr/wdata : memory command, i_mem_rdata : memory read data
//   o_busy              : high whenever the sequencer is not idle
//   o_grant_id          : last granted port (0 none, 1 host, 2 rd, 3 wb)
// ============================================================================
module weight_mem_arbiter #(
  parameter int ADDR_W     = 4,
  parameter int DW         = 8,
  parameter int STARVE_LIM = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_phase_infer,
  input  logic              i_host_req,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [DW-1:0]     i_host_wdata,
  output logic              o_host_ack,
  input  logic              i_rd_req,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              o_rd_valid,
  output logic [DW-1:0]     o_rd_data,
  input  logic              i_wb_req,
  input  logic [ADDR_W-1:0] i_wb_addr,
  input  logic [DW-1:0]     i_wb_wdata,
  output logic              o_wb_ack,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DW-1:0]     o_mem_wdata,
  input  logic [DW-1:0]     i_mem_rdata,
  output logic              o_busy,
  output logic [1:0]        o_grant_id
);

  localparam int                 c_cnt_w      = $clog2(STARVE_LIM + 1);
  localparam logic [c_cnt_w-1:0] c_starve_max = c_cnt_w'(STARVE_LIM);
  localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

  localparam logic [1:0] c_id_none = 2'd0;
  localparam logic [1:0] c_id_host = 2'd1;
  localparam logic [1:0] c_id_rd   = 2'd2;
  localparam logic [1:0] c_id_wb   = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_CAPT  = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next;
  logic [1:0]           r_served;
  logic [1:0]           r_mask;
  logic [c_cnt_w-1:0]   r_starve;
  logic [1:0]           w_grant;
  logic                 w_host_el;
  logic                 w_rd_el;
  logic                 w_wb_el;
  logic                 w_hold;

  logic                 r_host_ack;
  logic                 r_wb_ack;
  logic                 r_rd_valid;
  logic [DW-1:0]        r_rd_data;
  logic                 r_mem_we;
  logic [ADDR_W-1:0]    r_mem_addr;
  logic [DW-1:0]        r_mem_wdata;
  logic                 r_busy;
  logic [1:0]           r_grant_id;

  // Eligibility and fixed-priority arbitration (host > wb > rd, with the
  // starvation override promoting rd).
  always_comb begin
    w_host_el = i_host_req & ~i_phase_infer;
    w_rd_el   = i_rd_req & i_phase_infer;
    w_wb_el   = i_wb_req & i_phase_infer;

    // In the IDLE cycle right after a response the served port's req may
    // still be falling; it is indistinguishable from a fresh request, so the
    // decision is deferred one cycle rather than letting a lower-priority
    // port slip in ahead of it purely because of the mask.
    w_hold = ((r_mask == c_id_host) & w_host_el) |
             ((r_mask == c_id_rd)   & w_rd_el)   |
             ((r_mask == c_id_wb)   & w_wb_el);

    w_grant = c_id_none;
    if ((r_state == ST_IDLE) && !w_hold) begin
      if (w_rd_el && (r_starve == c_starve_max)) begin
        w_grant = c_id_rd;
      end else if (w_host_el) begin
        w_grant = c_id_host;
      end else if (w_wb_el) begin
        w_grant = c_id_wb;
      end else if (w_rd_el) begin
        w_grant = c_id_rd;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_grant == c_id_rd) begin
          w_next = ST_READ;
        end else if (w_grant != c_id_none) begin
          w_next = ST_WRITE;
        end
      end
      ST_WRITE: w_next = ST_RESP;
      ST_READ:  w_next = ST_CAPT;
      ST_CAPT:  w_next = ST_RESP;
      ST_RESP:  w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Registered outputs and bookkeeping
  always_ff @(posedge clk) begin
    if (rst) begin
      r_served    <= c_id_none;
      r_mask      <= c_id_none;
      r_starve    <= '0;
      r_host_ack  <= 1'b0;
      r_wb_ack    <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_busy      <= 1'b0;
      r_grant_id  <= c_id_none;
    end else begin
      r_mem_we   <= 1'b0;
      r_host_ack <= (r_state == ST_WRITE) && (r_served == c_id_host);
      r_wb_ack   <= (r_state == ST_WRITE) && (r_served == c_id_wb);
      r_rd_valid <= (r_state == ST_CAPT);
      r_busy     <= (w_next != ST_IDLE);
      // Mask is live only for the single IDLE cycle following RESP.
      r_mask     <= (r_state == ST_RESP) ? r_served : c_id_none;

      // Memory returns data during CAPT for the address driven in READ.
      if (r_state == ST_CAPT) begin
        r_rd_data <= i_mem_rdata;
      end

      case (w_grant)
        c_id_host: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= i_host_addr;
          r_mem_wdata <= i_host_wdata;
        end
        c_id_wb: begin
          r_mem_we    <= 1'b1;
          r_mem_addr  <= i_wb_addr;
          r_mem_wdata <= i_wb_wdata;
        end
        c_id_rd: begin
          r_mem_addr  <= i_rd_addr;
        end
        default: begin
        end
      endcase

      if (w_grant != c_id_none) begin
        r_served   <= w_grant;
        r_grant_id <= w_grant;
      end

      if (!i_rd_req || (w_grant == c_id_rd)) begin
        r_starve <= '0;
      end else if ((w_grant == c_id_wb) && (r_starve != c_starve_max)) begin
        r_starve <= r_starve + c_cnt_one;
      end
    end
  end

  assign o_host_ack  = r_host_ack;
  assign o_wb_ack    = r_wb_ack;
  assign o_rd_valid  = r_rd_valid;
  assign o_rd_data   = r_rd_data;
  assign o_mem_we    = r_mem_we;
  assign o_mem_addr  = r_mem_addr;
  assign o_mem_wdata = r_mem_wdata;
  assign o_busy      = r_busy;
  assign o_grant_id  = r_grant_id;

endmodule
`default_nettype wire

// File: tb/tb_weight_mem_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_weight_mem_arbiter
// Purpose  : Self-checking bench for weight_mem_arbiter with a behavioural
//            single-port memory and a memory-content scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_weight_mem_arbiter;

  localparam int ADDR_W     = 4;
  localparam int DW         = 8;
  localparam int STARVE_LIM = 4;
  localparam int DEPTH      = 1 << ADDR_W;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_phase_infer;
  logic              i_host_req;
  logic [ADDR_W-1:0] i_host_addr;
  logic [DW-1:0]     i_host_wdata;
  logic              o_host_ack;
  logic              i_rd_req;
  logic [ADDR_W-1:0] i_rd_addr;
  logic              o_rd_valid;
  logic [DW-1:0]     o_rd_data;
  logic              i_wb_req;
  logic [ADDR_W-1:0] i_wb_addr;
  logic [DW-1:0]     i_wb_wdata;
  logic              o_wb_ack;
  logic              o_mem_we;
  logic [ADDR_W-1:0] o_mem_addr;
  logic [DW-1:0]     o_mem_wdata;
  logic [DW-1:0]     i_mem_rdata;
  logic              o_busy;
  logic [1:0]        o_grant_id;

  int checks = 0;
  int errors = 0;

  // Behavioural memory plus a preload port used only by the bench
  logic [DW-1:0]     mem [0:DEPTH-1];
  logic              pl_we;
  logic [ADDR_W-1:0] pl_addr;
  logic [DW-1:0]     pl_data;

  // Reference model of memory contents
  logic [DW-1:0]     mdl [0:DEPTH-1];

  // Pending-request flags for the random requesters
  logic hp, rp, wp;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pl_we) mem[pl_addr] <= pl_data;
    else if (o_mem_we) mem[o_mem_addr] <= o_mem_wdata;
    i_mem_rdata <= mem[o_mem_addr];
  end

  weight_mem_arbiter #(
    .ADDR_W(ADDR_W), .DW(DW), .STARVE_LIM(STARVE_LIM)
  ) dut (
    .clk(clk), .rst(rst), .i_phase_infer(i_phase_infer),
    .i_host_req(i_host_req), .i_host_addr(i_host_addr),
    .i_host_wdata(i_host_wdata), .o_host_ack(o_host_ack),
    .i_rd_req(i_rd_req), .i_rd_addr(i_rd_addr),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data),
    .i_wb_req(i_wb_req), .i_wb_addr(i_wb_addr),
    .i_wb_wdata(i_wb_wdata), .o_wb_ack(o_wb_ack),
    .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata),
    .o_busy(o_busy), .o_grant_id(o_grant_id)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int c;
    c = 0;
    while (o_busy && c < 20) begin
      tick();
      c++;
    end
    checks++;
    if (o_busy !== 1'b0) begin
      errors++;
      $display("FAIL drain_timeout: busy=%b required 0", o_busy);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_phase_infer = 1'b0;
    i_host_req = 1'b1; i_host_addr = 4'd5; i_host_wdata = 8'hA7;
    for (int c = 0; c < 2; c++) begin
      tick();
      checks++;
      if ({o_host_ack, o_wb_ack, o_rd_valid, o_mem_we, o_busy, o_rd_data,
           o_mem_addr, o_mem_wdata, o_grant_id} !== '0) begin
        errors++;
        $display("FAIL reset_outputs: ack=%b wb=%b rv=%b we=%b busy=%b rd=%h a=%h d=%h g=%0d required all 0",
                 o_host_ack, o_wb_ack, o_rd_valid, o_mem_we, o_busy, o_rd_data,
                 o_mem_addr, o_mem_wdata, o_grant_id);
      end
    end
    rst = 1'b0;
    tick();
    checks++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 4'd5 || o_mem_wdata !== 8'hA7 ||
        o_host_ack !== 1'b0 || o_grant_id !== 2'd1) begin
      errors++;
      $display("FAIL host_write_cmd: we=%b a=%h d=%h ack=%b g=%0d required we=1 a=5 d=a7 ack=0 g=1",
               o_mem_we, o_mem_addr, o_mem_wdata, o_host_ack, o_grant_id);
    end
    tick();
    checks++;
    if (o_host_ack !== 1'b1 || o_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL host_ack_pulse: ack=%b we=%b required ack=1 we=0", o_host_ack, o_mem_we);
    end
    mdl[5] = 8'hA7;
    i_host_req = 1'b0;
    begin
      int extra;
      extra = 0;
      for (int c = 0; c < 6; c++) begin
        tick();
        if (o_mem_we || o_host_ack) extra++;
      end
      checks++;
      if (extra != 0 || o_busy !== 1'b0) begin
        errors++;
        $display("FAIL host_single_write: extra=%0d busy=%b required extra=0 busy=0", extra, o_busy);
      end
    end
    checks++;
    if (mem[5] !== 8'hA7) begin
      errors++;
      $display("FAIL host_mem_content: got %h required a7", mem[5]);
    end
  endtask

  task automatic test_read_latency();
    logic [3:1] seen;
    int wr;
    pl_we = 1'b1; pl_addr = 4'd9; pl_data = 8'h3C;
    tick();
    pl_we = 1'b0;
    mdl[9] = 8'h3C;
    i_phase_infer = 1'b1;
    i_rd_req = 1'b1; i_rd_addr = 4'd9;
    seen = '0;
    wr = 0;
    for (int c = 1; c <= 3; c++) begin
      tick();
      seen[c] = o_rd_valid;
      if (o_mem_we) wr++;
      if (c == 1) begin
        checks++;
        if (o_mem_addr !== 4'd9) begin
          errors++;
          $display("FAIL read_addr: got %h required 9", o_mem_addr);
        end
      end
    end
    checks++;
    if (seen !== 3'b100 || o_rd_data !== 8'h3C) begin
      errors++;
      $display("FAIL read_latency: valid_pattern=%b data=%h required 100 data=3c", seen, o_rd_data);
    end
    checks++;
    if (wr != 0) begin
      errors++;
      $display("FAIL read_no_write: we_cycles=%0d required 0", wr);
    end
    i_rd_req = 1'b0;
    tick();
    checks++;
    if (o_busy !== 1'b0 || o_rd_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_back_idle: busy=%b valid=%b required 0 0", o_busy, o_rd_valid);
    end
  endtask

  task automatic test_starvation();
    int ev [0:5];
    int exp_ev;
    int n, cyc;
    logic [ADDR_W-1:0] ra;
    ra = ADDR_W'($urandom);
    i_phase_infer = 1'b1;
    i_wb_req = 1'b1; i_wb_addr = ADDR_W'($urandom); i_wb_wdata = DW'($urandom);
    i_rd_req = 1'b1; i_rd_addr = ra;
    n = 0; cyc = 0;
    while (n < 6 && cyc < 100) begin
      tick();
      cyc++;
      if (o_wb_ack) begin
        mdl[i_wb_addr] = i_wb_wdata;
        if (n < 6) ev[n] = 3;
        n++;
      end
      if (o_rd_valid) begin
        checks++;
        if (o_grant_id !== 2'd2 || o_rd_data !== mdl[ra]) begin
          errors++;
          $display("FAIL starve_rd_grant: g=%0d data=%h required g=2 data=%h", o_grant_id, o_rd_data, mdl[ra]);
        end
        if (n < 6) ev[n] = 2;
        n++;
      end
    end
    i_wb_req = 1'b0; i_rd_req = 1'b0;
    checks++;
    if (n < 6) begin
      errors++;
      $display("FAIL starve_timeout: events=%0d required 6", n);
    end else begin
      for (int k = 0; k < 6; k++) begin
        exp_ev = (k == STARVE_LIM) ? 2 : 3;
        checks++;
        if (ev[k] != exp_ev) begin
          errors++;
          $display("FAIL starve_order[%0d]: port=%0d required %0d", k, ev[k], exp_ev);
        end
      end
    end
    drain();
  endtask

  task automatic test_phase_gating();
    int bad;
    i_phase_infer = 1'b0;
    i_rd_req = 1'b1; i_rd_addr = ADDR_W'($urandom);
    i_wb_req = 1'b1; i_wb_addr = 4'd12; i_wb_wdata = DW'($urandom);
    bad = 0;
    for (int c = 0; c < 20; c++) begin
      tick();
      if (o_busy || o_mem_we || o_wb_ack || o_rd_valid) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL gating_no_grant: active_cycles=%0d required 0", bad);
    end
    i_phase_infer = 1'b1;
    tick();
    checks++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 4'd12 || o_grant_id !== 2'd3) begin
      errors++;
      $display("FAIL gating_wb_first: we=%b a=%h g=%0d required we=1 a=c g=3", o_mem_we, o_mem_addr, o_grant_id);
    end
    tick();
    checks++;
    if (o_wb_ack !== 1'b1) begin
      errors++;
      $display("FAIL gating_wb_ack: got %b required 1", o_wb_ack);
    end
    mdl[12] = i_wb_wdata;
    i_wb_req = 1'b0; i_rd_req = 1'b0;
    drain();
  endtask

  task automatic test_phase_flip();
    logic [ADDR_W-1:0] ra;
    int early;
    ra = ADDR_W'($urandom);
    i_phase_infer = 1'b1;
    i_rd_req = 1'b1; i_rd_addr = ra;
    i_host_req = 1'b1; i_host_addr = 4'd3; i_host_wdata = DW'($urandom);
    early = 0;
    tick();
    checks++;
    if (o_mem_addr !== ra || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL flip_read_start: a=%h busy=%b required a=%h busy=1", o_mem_addr, o_busy, ra);
    end
    i_phase_infer = 1'b0;
    tick();
    if (o_mem_we) early++;
    tick();
    if (o_mem_we) early++;
    checks++;
    if (o_rd_valid !== 1'b1 || o_rd_data !== mdl[ra]) begin
      errors++;
      $display("FAIL flip_rd_valid: valid=%b data=%h required 1 %h", o_rd_valid, o_rd_data, mdl[ra]);
    end
    i_rd_req = 1'b0;
    tick();
    if (o_mem_we) early++;
    checks++;
    if (early != 0) begin
      errors++;
      $display("FAIL flip_host_early: we_cycles=%0d required 0", early);
    end
    tick();
    checks++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 4'd3 || o_grant_id !== 2'd1) begin
      errors++;
      $display("FAIL flip_host_after: we=%b a=%h g=%0d required we=1 a=3 g=1", o_mem_we, o_mem_addr, o_grant_id);
    end
    tick();
    checks++;
    if (o_host_ack !== 1'b1) begin
      errors++;
      $display("FAIL flip_host_ack: got %b required 1", o_host_ack);
    end
    mdl[3] = i_host_wdata;
    i_host_req = 1'b0;
    drain();
  endtask

  task automatic test_reset_mid_write();
    i_phase_infer = 1'b1;
    i_wb_req = 1'b1; i_wb_addr = 4'd7; i_wb_wdata = DW'($urandom);
    tick();
    checks++;
    if (o_mem_we !== 1'b1) begin
      errors++;
      $display("FAIL rstw_write_cycle: we=%b required 1", o_mem_we);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (o_wb_ack !== 1'b0 || o_busy !== 1'b0 || o_mem_we !== 1'b0) begin
      errors++;
      $display("FAIL rstw_abort: ack=%b busy=%b we=%b required 0 0 0", o_wb_ack, o_busy, o_mem_we);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (o_mem_we !== 1'b1 || o_mem_addr !== 4'd7 || o_wb_ack !== 1'b0) begin
      errors++;
      $display("FAIL rstw_regrant: we=%b a=%h ack=%b required we=1 a=7 ack=0", o_mem_we, o_mem_addr, o_wb_ack);
    end
    tick();
    checks++;
    if (o_wb_ack !== 1'b1) begin
      errors++;
      $display("FAIL rstw_ack: got %b required 1", o_wb_ack);
    end
    mdl[7] = i_wb_wdata;
    i_wb_req = 1'b0;
    drain();
  endtask

  task automatic observe_random();
    int nev;
    nev = int'(o_host_ack) + int'(o_wb_ack) + int'(o_rd_valid);
    checks++;
    if (nev > 1) begin
      errors++;
      $display("FAIL rand_one_event: events=%0d required at most 1", nev);
    end
    if (o_mem_we) begin
      checks++;
      if (!((hp && o_mem_addr == i_host_addr && o_mem_wdata == i_host_wdata) ||
            (wp && o_mem_addr == i_wb_addr && o_mem_wdata == i_wb_wdata))) begin
        errors++;
        $display("FAIL rand_write_cmd: a=%h d=%h matches no pending writer", o_mem_addr, o_mem_wdata);
      end
    end
    if (o_host_ack) begin
      checks++;
      if (!hp || mem[i_host_addr] !== i_host_wdata) begin
        errors++;
        $display("FAIL rand_host_ack: pending=%b mem=%h required pending=1 mem=%h", hp, mem[i_host_addr], i_host_wdata);
      end
      mdl[i_host_addr] = i_host_wdata;
      hp = 1'b0; i_host_req = 1'b0;
    end
    if (o_wb_ack) begin
      checks++;
      if (!wp || mem[i_wb_addr] !== i_wb_wdata) begin
        errors++;
        $display("FAIL rand_wb_ack: pending=%b mem=%h required pending=1 mem=%h", wp, mem[i_wb_addr], i_wb_wdata);
      end
      mdl[i_wb_addr] = i_wb_wdata;
      wp = 1'b0; i_wb_req = 1'b0;
    end
    if (o_rd_valid) begin
      checks++;
      if (!rp || o_rd_data !== mdl[i_rd_addr]) begin
        errors++;
        $display("FAIL rand_rd_data: pending=%b data=%h required pending=1 data=%h", rp, o_rd_data, mdl[i_rd_addr]);
      end
      rp = 1'b0; i_rd_req = 1'b0;
    end
  endtask

  task automatic test_random();
    hp = 1'b0; rp = 1'b0; wp = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      if (!hp && $urandom_range(0, 3) == 0) begin
        hp = 1'b1; i_host_req = 1'b1;
        i_host_addr = ADDR_W'($urandom); i_host_wdata = DW'($urandom);
      end
      if (!rp && $urandom_range(0, 2) == 0) begin
        rp = 1'b1; i_rd_req = 1'b1; i_rd_addr = ADDR_W'($urandom);
      end
      if (!wp && $urandom_range(0, 2) == 0) begin
        wp = 1'b1; i_wb_req = 1'b1;
        i_wb_addr = ADDR_W'($urandom); i_wb_wdata = DW'($urandom);
      end
      if ($urandom_range(0, 19) == 0) i_phase_infer = ~i_phase_infer;
      tick();
      observe_random();
    end
    i_phase_infer = 1'b0;
    for (int c = 0; c < 60 && hp; c++) begin
      tick();
      observe_random();
    end
    i_phase_infer = 1'b1;
    for (int c = 0; c < 150 && (rp || wp); c++) begin
      tick();
      observe_random();
    end
    checks++;
    if (hp || rp || wp) begin
      errors++;
      $display("FAIL rand_drain: pending host=%b rd=%b wb=%b required all 0", hp, rp, wp);
    end
    drain();
  endtask

  initial begin
    rst = 1'b1;
    i_phase_infer = 1'b0;
    i_host_req = 1'b0; i_host_addr = '0; i_host_wdata = '0;
    i_rd_req = 1'b0; i_rd_addr = '0;
    i_wb_req = 1'b0; i_wb_addr = '0; i_wb_wdata = '0;
    pl_we = 1'b0; pl_addr = '0; pl_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      pl_we = 1'b1; pl_addr = ADDR_W'(i); pl_data = DW'($urandom);
      mdl[i] = pl_data;
      tick();
    end
    pl_we = 1'b0;

    test_reset();
    test_read_latency();
    test_starvation();
    test_phase_gating();
    test_phase_flip();
    test_reset_mid_write();
    test_random();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/weight_mem_arbiter.md
# weight_mem_arbiter

Sequencer and arbiter for the shared single-port weight memory (synchronous read, 1-cycle latency). Serves three requesters through req/ack handshakes: the host weight-load port, the inference weight-read port and the learning write-back port. Drives the memory's `we/addr/wdata` and returns read data. Sits between the top-level phase logic and the `Memory` / `Multilayer` instances.

## Interface
- `ADDR_W`, 4, weight address width
- `DW`, 8, weight data width
- `STARVE_LIM`, 4, consecutive non-read grants tolerated while a read waits (≥1)
- `clk`  in  1  single clock, all logic on rising edge
- `rst`  in  1  reset: synchronous, active-high
- `phase_infer`  in  1  0 = host load phase, 1 = inference/learning phase
- `host_req`  in  1  host write request; `host_addr` in ADDR_W; `host_wdata` in DW
- `host_ack`  out  1  one-cycle pulse, host write done
- `rd_req`  in  1  inference read request; `rd_addr` in ADDR_W
- `rd_valid`  out  1  one-cycle pulse, `rd_data` valid
- `rd_data`  out  DW  read data, held until next read completes
- `wb_req`  in  1  write-back request; `wb_addr` in ADDR_W; `wb_wdata` in DW
- `wb_ack`  out  1  one-cycle pulse, write-back done
- `mem_we`  out  1  memory write enable
- `mem_addr`  out  ADDR_W  memory address
- `mem_wdata`  out  DW  memory write data
- `mem_rdata`  in  DW  memory read data, valid the cycle after `mem_addr` is presented with `mem_we=0`
- `busy`  out  1  high in any state other than IDLE
- `grant_id`  out  2  last granted port: 0 none, 1 host, 2 read, 3 write-back

## Operation
- States: IDLE, WRITE, READ, CAPT, RESP.
- Requesters hold req and addr/data stable until their ack/valid. The arbiter never drops an accepted request.
- Eligibility:
  - `phase_infer=0`: only `host_req` is eligible.
  - `phase_infer=1`: only `rd_req` and `wb_req` are eligible.
  - Ineligible requests wait and are never acked.
- Arbitration runs only in IDLE. Fixed priority is host > wb > rd.
- Starvation override: if `starve_cnt == STARVE_LIM` and `rd_req` is eligible, rd wins.
- `starve_cnt`:
  - increments, saturating at STARVE_LIM, on each wb grant while `rd_req` is high.
  - clears on a rd grant, or on any cycle where `rd_req=0`.
- Host or wb grant: IDLE→WRITE. `mem_we=1`, `mem_addr/mem_wdata` from the granted port for exactly one cycle. Then RESP with the ack pulse, then IDLE.
- Read grant: IDLE→READ (`mem_addr=rd_addr`, `mem_we=0`) → CAPT (capture `mem_rdata` into `rd_data`) → RESP (`rd_valid=1`) → IDLE.
- In RESP, the port just served is masked in the following IDLE cycle. This prevents a double grant while its req is falling.
- A phase change mid-operation does not abort. The in-flight op completes and acks. Eligibility changes apply only at the next IDLE.
- `mem_we` is 0 in every state except WRITE. `mem_addr/mem_wdata` hold their last value outside WRITE/READ.
- `grant_id` updates on the grant edge and holds until the next grant.

## Timing
- Reset values:
  - state IDLE; `starve_cnt` 0; mask none
  - `host_ack`, `wb_ack`, `rd_valid`, `mem_we`, `busy` all 0
  - `rd_data`, `mem_addr`, `mem_wdata` all 0; `grant_id` 0
- Reset asserted mid-operation returns to IDLE next cycle. No ack or valid is emitted for the aborted op.
- Write latency: req sampled in IDLE at cycle n → `mem_we=1` in n+1 → ack in n+2. IDLE at n+3.
- Read latency: req sampled at n → `mem_addr` in n+1 → `rd_data` registered end of n+2 → `rd_valid` in n+3. IDLE at n+4.
- Throughput: one write per 3 cycles, one read per 4 cycles.
- All outputs are registered. There is no combinational path from any req to any memory output.

## Test plan
- Reset and host load:
  - Stimulus: `rst` held 2 cycles; `phase_infer=0`, `host_req` with addr 5, data 0xA7.
  - Required: all outputs 0 during reset; `mem_we=1`/`mem_addr=5`/`mem_wdata=0xA7` one cycle after the req; `host_ack` pulse the next cycle; a single write only.
- Read latency:
  - Stimulus: `phase_infer=1`, memory preloaded with 0x3C at addr 9, `rd_req` addr 9.
  - Required: `rd_valid` exactly 3 cycles after the sampling edge with `rd_data=0x3C`; `mem_we` stays 0.
- Priority and starvation (STARVE_LIM=4):
  - Stimulus: `rd_req` and `wb_req` held continuously.
  - Required: 4 wb_acks, then a rd grant (`grant_id=2`), then wb resumes.
- Phase gating:
  - Stimulus: `phase_infer=0` with `rd_req` and `wb_req` held 20 cycles.
  - Required: no grant, `busy=0`. After `phase_infer` goes to 1, wb is granted first.
- Phase flip mid-read:
  - Stimulus: drop `phase_infer` in the READ cycle.
  - Required: `rd_valid` still pulses; the host is granted only afterwards.
- Reset mid-write:
  - Stimulus: `rst` asserted in the WRITE cycle.
  - Required: no `wb_ack`; IDLE next cycle; a re-requested wb completes normally.
